// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state/source encodings, default geometry and a saturating counter helper
package mem_ctrl_pkg;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_DRAIN = 3'd3,
    DONE     = 3'd4
  } state_e;
  typedef enum logic [1:0] {
    SRC_I  = 2'd0,
    SRC_D  = 2'd1,
    SRC_DL = 2'd2
  } src_e;
  function automatic logic [15:0] sat_inc16(input logic [15:0] c, input logic hit);
    return (hit && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction
endpackage

// File: rtl/mem_rd_lat_pipe.sv
// mem_rd_lat_pipe: RD_LAT-deep valid + beat-index shift register tracking reads in flight
module mem_rd_lat_pipe #(
  parameter int RD_LAT = 2,
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [BW-1:0] push_idx,
  output logic          out_vld,
  output logic [BW-1:0] out_idx,
  output logic          drained
);
  localparam logic [RD_LAT-1:0] LAST = RD_LAT'(1) << (RD_LAT - 1);
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT*BW-1:0] idx_q, idx_d;
  // shift one stage per cycle; the oldest entry is the one returning now
  always_comb begin
    vld_d = (vld_q << 1) | RD_LAT'(push);
    idx_d = (idx_q << BW) | (RD_LAT*BW)'(push_idx);
    out_vld = vld_q[RD_LAT-1];
    out_idx = idx_q[RD_LAT*BW-1 -: BW];
    drained = ~|(vld_q & ~LAST);
  end
  // pipe registers, cleared by reset so in-flight returns are dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one granted line access into word beats on the SRAM; MEM_ACCESS_CTRL_PERF_CNT_EN adds per-source done counters
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int RD_LAT = 2,
  localparam int BW = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i_m_areg_m,
  input  logic              v_d_m_areg_m,
  input  logic              v_m_download_m,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              wdata_rd,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic [BW-1:0]     rdata_beat,
  output logic              mem_access_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]       perf_i_cnt,
  output logic [15:0]       perf_d_cnt,
  output logic [15:0]       perf_dl_cnt
`endif
);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * DATA_W / 8 - 1);
  localparam logic [ADDR_W-1:0] WSTEP = ADDR_W'(DATA_W / 8);
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BW-1:0] beat_q, beat_d;
  logic issue, rd_push, pipe_vld, drained;
  logic [BW-1:0] pipe_idx;
  mem_rd_lat_pipe #(.RD_LAT(RD_LAT), .BW(BW)) u_pipe (
    .clk(clk), .rst(rst), .push(rd_push), .push_idx(beat_q),
    .out_vld(pipe_vld), .out_idx(pipe_idx), .drained(drained)
  );
  // grant capture in IDLE (i > d > download), then beat sequencing
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    beat_d = beat_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        base_d = req_addr & ~OFF_MASK;
        state_d = v_i_m_areg_m ? RD_ISSUE :
                  v_d_m_areg_m ? (req_rw ? WRITE : RD_ISSUE) :
                  v_m_download_m ? WRITE : IDLE;
      end
      WRITE, RD_ISSUE: begin
        beat_d = beat_q + BW'(1);
        if (beat_q == LAST) state_d = (state_q == WRITE) ? DONE : RD_DRAIN;
      end
      RD_DRAIN: if (drained) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // SRAM drive and read return; everything is gated to 0 outside its own state
  always_comb begin
    issue = state_q == WRITE || state_q == RD_ISSUE;
    rd_push = state_q == RD_ISSUE;
    mem_en = issue;
    mem_we = state_q == WRITE;
    wdata_rd = mem_we;
    mem_wdata = mem_we ? wdata_in : '0;
    mem_addr = issue ? base_q + ADDR_W'(beat_q) * WSTEP : '0;
    rdata_valid = pipe_vld;
    rdata_out = pipe_vld ? mem_rdata : '0;
    rdata_beat = pipe_vld ? pipe_idx : '0;
    mem_access_done = state_q == DONE;
    busy = state_q != IDLE;
  end
  // sequencer state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q <= '0;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      beat_q <= beat_d;
    end
  end
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
  src_e src_q, src_d;
  logic [15:0] perf_i_q, perf_i_d, perf_d_q, perf_d_d, perf_dl_q, perf_dl_d;
  // source of the current access and saturating per-source completion counts
  always_comb begin
    src_d = (state_q != IDLE) ? src_q : v_i_m_areg_m ? SRC_I : v_d_m_areg_m ? SRC_D : SRC_DL;
    perf_i_d = sat_inc16(perf_i_q, mem_access_done && src_q == SRC_I);
    perf_d_d = sat_inc16(perf_d_q, mem_access_done && src_q == SRC_D);
    perf_dl_d = sat_inc16(perf_dl_q, mem_access_done && src_q == SRC_DL);
    perf_i_cnt = perf_i_q;
    perf_d_cnt = perf_d_q;
    perf_dl_cnt = perf_dl_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q <= SRC_I;
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_dl_q <= '0;
    end else begin
      src_q <= src_d;
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
      perf_dl_q <= perf_dl_d;
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed + random line accesses checked cycle by cycle against a transaction-level model
module tb_mem_access_ctrl;
  localparam int AW = 32, DW = 32, LW = 4, RL = 2, BW = $clog2(LW);
  localparam int VW = 4 + AW + DW + 1 + BW + DW + 1;
  logic clk = 0, rst = 0;
  logic v_i = 0, v_d = 0, v_dl = 0, req_rw = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] wdata_in = '0, rdata_out, mem_wdata, mem_rdata;
  logic wdata_rd, rdata_valid, mem_access_done, mem_en, mem_we, busy;
  logic [BW-1:0] rdata_beat;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
  logic [15:0] perf_i_cnt, perf_d_cnt, perf_dl_cnt;
`endif
  int checks = 0, errors = 0;
  int cnt [3];
  logic [DW-1:0] wd [LW];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] sram [logic [AW-1:0]];
  logic [DW-1:0] rd [RL];
  logic rv [RL];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .v_i_m_areg_m(v_i), .v_d_m_areg_m(v_d), .v_m_download_m(v_dl),
    .req_rw(req_rw), .req_addr(req_addr), .wdata_in(wdata_in), .wdata_rd(wdata_rd),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .rdata_beat(rdata_beat),
    .mem_access_done(mem_access_done), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
    , .perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt), .perf_dl_cnt(perf_dl_cnt)
`endif
  );

  function automatic logic [DW-1:0] sram_val(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : a ^ 32'hFFFF;
  endfunction

  function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a ^ 32'hFFFF;
  endfunction

  // SRAM stand-in: stores writes, returns read data RL cycles after the enable
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] = mem_wdata;
    for (int i = RL - 1; i > 0; i--) begin
      rd[i] <= rd[i-1];
      rv[i] <= rv[i-1];
    end
    rd[0] <= sram_val(mem_addr);
    rv[0] <= mem_en && !mem_we;
  end
  assign mem_rdata = rv[RL-1] ? rd[RL-1] : '0;

  function automatic logic [VW-1:0] obs();
    return {busy, mem_en, mem_we, wdata_rd, mem_addr, mem_wdata, rdata_valid, rdata_beat, rdata_out, mem_access_done};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic access(input bit gi, input bit gd, input bit gdl, input bit rw,
                        input logic [AW-1:0] addr, input bit drop, input bit rnd_wd, input int abort_k);
    bit wr, e_we, e_rv;
    int n, src;
    logic [AW-1:0] base, e_addr;
    logic [DW-1:0] e_rd;
    src = gi ? 0 : gd ? 1 : 2;
    wr = gi ? 1'b0 : gd ? rw : 1'b1;
    base = addr & ~AW'(LW * DW / 8 - 1);
    n = wr ? LW + 1 : LW + RL + 1;
    if (rnd_wd) foreach (wd[j]) wd[j] = $urandom;
    @(negedge clk);
    v_i = gi; v_d = gd; v_dl = gdl; req_rw = rw; req_addr = addr;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (drop) {v_i, v_d, v_dl} = '0;
      req_addr = $urandom;
      req_rw = 1'($urandom);
      wdata_in = (wr && k < LW) ? wd[k] : $urandom;
      #1;
      e_we = wr && k < LW;
      e_addr = (k < LW) ? base + AW'(4 * k) : '0;
      e_rv = !wr && k >= RL && k < RL + LW;
      e_rd = e_rv ? ref_val(base + AW'(4 * (k - RL))) : '0;
      chk($sformatf("src%0d wr%0d base=%h cyc%0d", src, wr, base, k), obs(),
          {1'b1, k < LW, e_we, e_we, e_addr, e_we ? wd[k] : DW'(0),
           e_rv, e_rv ? BW'(k - RL) : BW'(0), e_rd, k == n - 1});
      if (e_we) ref_mem[base + AW'(4 * k)] = wd[k];
      if (k == abort_k) begin
        rst = 0;
        {v_i, v_d, v_dl} = '0;
        return;
      end
    end
    if (cnt[src] < 65535) cnt[src]++;
    @(negedge clk);
    {v_i, v_d, v_dl} = '0;
    #1 chk("idle_after_done", obs(), '0);
  endtask

  initial begin
    logic [2:0] g;
    logic [AW-1:0] a;
    cnt = '{0, 0, 0};
    v_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk("reset_outputs", obs(), '0);
    rst = 1; v_i = 0;
    @(negedge clk);
    #1 chk("idle_first", obs(), '0);
    wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    access(0, 0, 1, 0, 32'h1000, 0, 0, -1);
    access(1, 0, 0, 0, 32'h2010, 0, 1, -1);
    access(1, 1, 0, 1, 32'h1008, 0, 1, -1);
    access(0, 1, 0, 1, 32'h2004, 1, 1, -1);
    access(0, 1, 0, 0, 32'h2008, 0, 1, -1);
    access(1, 0, 0, 0, 32'h1004, 1, 1, -1);
    access(0, 0, 1, 0, 32'hFFFF_FFFC, 0, 1, -1);
    access(0, 1, 0, 0, 32'hFFFF_FFF4, 0, 1, -1);
    access(1, 0, 0, 0, 32'h3000, 0, 1, LW);
    @(negedge clk);
    #1 chk("rst_mid_drain", obs(), '0);
    rst = 1;
    @(negedge clk);
    #1 chk("after_rst_release", obs(), '0);
    @(negedge clk);
    #1 chk("no_late_done", obs(), '0);
    cnt = '{0, 0, 0};
    for (int r = 0; r < 30; r++) begin
      g = 3'($urandom_range(1, 7));
      a = 32'h3000 + AW'($urandom_range(0, 7) << 4) + AW'($urandom_range(0, 15));
      access(g[0], g[1], g[2], 1'($urandom), a, 1'($urandom), 1, -1);
    end
`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
    chk("perf_counts", VW'({perf_i_cnt, perf_d_cnt, perf_dl_cnt}),
        VW'({16'(cnt[0]), 16'(cnt[1]), 16'(cnt[2])}));
    @(negedge clk);
    force dut.perf_dl_q = 16'hFFFE;
    @(negedge clk);
    release dut.perf_dl_q;
    repeat (3) access(0, 0, 1, 0, 32'h4000, 0, 1, -1);
    chk("perf_dl_saturate", VW'(perf_dl_cnt), VW'(16'hFFFF));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one granted memory access at a time onto the single-port main-memory SRAM.
- Sits directly behind the three-way memory arbiter: i-side miss fill, d-side miss/writeback, and network download.
- Converts one line-sized request into LINE_WORDS word beats.
- Returns read data beat by beat and pulses mem_access_done so the arbiter can release its grant.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, memory word width.
- LINE_WORDS, 4, words per line; power of two, 2..16.
- RD_LAT, 2, fixed SRAM read latency in cycles; range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- v_i_m_areg_m  in  1  i-side grant valid from arbiter; read-only.
- v_d_m_areg_m  in  1  d-side grant valid from arbiter.
- v_m_download_m  in  1  download grant valid from arbiter; write-only.
- req_rw  in  1  d-side direction: 1 = write, 0 = read. Ignored for the other two sources.
- req_addr  in  ADDR_W  line address of the granted request.
- wdata_in  in  DATA_W  write word for the current beat; must be valid in the cycle wdata_rd=1.
- wdata_rd  out  1  pops one write word from the granted source.
- rdata_out  out  DATA_W  returned read word.
- rdata_valid  out  1  rdata_out is valid this cycle.
- rdata_beat  out  log2(LINE_WORDS)  word index of rdata_out.
- mem_access_done  out  1  one-cycle completion pulse to the arbiter.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM word byte-address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after a read enable.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (rst=0 at posedge clk): state=IDLE, beat counters=0, read pipe cleared. All outputs are 0.
- States: IDLE, WRITE, RD_ISSUE, RD_DRAIN, DONE.
- IDLE:
  - Sample grants with priority i > d > download; more than one grant high is an arbiter bug, and the higher priority wins.
  - Latch source, direction and base address, with low log2(LINE_WORDS*DATA_W/8) bits forced to 0.
  - Go to WRITE (download, or d-side with req_rw=1) or RD_ISSUE (i-side, or d-side with req_rw=0). First beat is issued the next cycle.
- WRITE:
  - Each cycle: mem_en=1, mem_we=1, wdata_rd=1, mem_wdata=wdata_in, mem_addr=base+beat*DATA_W/8.
  - Beat increments each cycle. After beat LINE_WORDS-1 go to DONE.
- RD_ISSUE:
  - Each cycle: mem_en=1, mem_we=0, mem_addr as in WRITE.
  - A tag carrying the beat index enters an RD_LAT-deep valid/index shift pipe.
  - After the last issue go to RD_DRAIN.
- RD_DRAIN: wait until the pipe is empty, then go to DONE.
- Read return: rdata_valid=1, rdata_out=mem_rdata, rdata_beat=tag index, exactly RD_LAT cycles after each issue, in order. Valid in RD_ISSUE and RD_DRAIN.
- DONE: mem_access_done=1 for one cycle, then IDLE. Grants seen in DONE are ignored.
- Grants are re-sampled only in IDLE, so the minimum gap between accesses is 1 idle cycle.
- Latency:
  - Write: LINE_WORDS+1 cycles from grant sample to done.
  - Read: LINE_WORDS+RD_LAT+1 cycles from grant sample to done.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is allowed and not flagged.
- Grant dropped mid-access: ignored. The access completes.
- Reset mid-access: abandon at once. In-flight read returns are discarded and no done pulse is produced.

Optional Feature:
- Macro: MEM_ACCESS_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_i_cnt, perf_d_cnt, perf_dl_cnt, each 16 bits.
  - A counter increments on the mem_access_done of its source.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state encoding: IDLE=0, WRITE=1, RD_ISSUE=2, RD_DRAIN=3, DONE=4, 3 bits;
  - source encoding: SRC_I=0, SRC_D=1, SRC_DL=2;
  - default LINE_WORDS/DATA_W constants.
- One natural sub-module: mem_rd_lat_pipe, the RD_LAT-deep valid+beat-index shift register with an empty flag.

Test Plan:
- Download write, base 0x1000, wdata 0xA0..0xA3:
  - mem_we=1 at addresses 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles.
  - done pulses 5 cycles after the grant sample.
- I-side read, address 0x2010, RD_LAT=2, SRAM returns addr^0xFFFF:
  - base forced to 0x2000;
  - rdata beats 0..3 in order;
  - done 7 cycles after the grant sample.
- Simultaneous v_i_m_areg_m=1 and v_d_m_areg_m=1: i-side read is performed and d-side is ignored; exactly one done pulse.
- d-side req_rw=1, grant dropped after 1 cycle: all 4 write beats are still issued and done pulses once.
- rst=0 asserted during RD_DRAIN: next cycle all outputs are 0, state is IDLE, no rdata_valid and no done.
- With MEM_ACCESS_CTRL_PERF_CNT_EN, perf_dl_cnt preloaded to 0xFFFE and 3 downloads run: counter reads 0xFFFF and holds.
